wb_mtimer: RTL
==============

WB_MTIMER -- requirements
Module: wb_mtimer

Interface
REQ-001 SHALL have parameter DIV_RST, default 16'd0: reset value of the prescaler divisor.
REQ-002 SHALL have parameter EN_RST, default 1'b1: reset value of the counter enable.
REQ-003 SHALL have port wb_clk_i, input, 1: the single clock.
REQ-004 SHALL have port wb_rst_i, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port wb_adr_i, input, 5: byte address; only bits [4:2] are decoded.
REQ-006 SHALL have port wb_dat_i, input, 32: write data.
REQ-007 SHALL have port wb_dat_o, output, 32: read data.
REQ-008 SHALL have port wb_sel_i, input, 4: byte lane enables.
REQ-009 SHALL have ports wb_we_i, wb_stb_i and wb_cyc_i, each input, 1: Wishbone write enable, strobe and cycle.
REQ-010 SHALL have port wb_ack_o, output, 1: transfer acknowledge.
REQ-011 SHALL have port timer_int_o, output, 1: machine timer interrupt, level.
REQ-012 SHALL have port soft_int_o, output, 1: machine software interrupt, level.

Function
REQ-013 SHALL decode the register map at word offsets 0x00 MTIME_LO, 0x04 MTIME_HI, 0x08 MTIMECMP_LO, 0x0C MTIMECMP_HI, 0x10 CTRL, 0x14 MSIP; offsets 0x18/0x1C read 0 and ignore writes.
REQ-014 SHALL lay out CTRL as bit0 EN, bits[31:16] DIV, other bits read 0; MSIP bit0 only, other bits read 0.
REQ-015 SHALL assert wb_ack_o for exactly one cycle, registered, one cycle after wb_cyc_i&wb_stb_i are seen high with wb_ack_o low; no wait states; no err or retry.
REQ-016 SHALL launch a new request on the cycle after an ack only if stb is still high, so back-to-back accesses ack every other cycle.
REQ-017 SHALL commit writes on the cycle the request is accepted; each byte is updated only when its wb_sel_i bit is set.
REQ-018 SHALL register wb_dat_o with wb_ack_o; wb_dat_o is 0 whenever wb_ack_o is low.
REQ-019 SHALL run the prescaler counter pc from 0 to DIV and then back to 0, emitting a one-cycle tick on wrap; DIV=0 gives a tick every cycle.
REQ-020 SHALL increment the 64-bit mtime by 1 on each tick while EN=1, wrapping from 0xFFFF_FFFF_FFFF_FFFF to 0.
REQ-021 SHALL, while EN=0, hold both mtime and pc, with pc cleared to 0.
REQ-022 SHALL give a bus write to MTIME_LO or MTIME_HI priority over an increment in the same cycle; the untouched half keeps its value with no carry applied that cycle.
REQ-023 SHALL, on a CTRL write that changes DIV, clear pc to 0.
REQ-024 SHALL drive timer_int_o as a register equal to (mtime >= mtimecmp), unsigned 64-bit, evaluated on next-state values, so it reflects any update one cycle after that update.
REQ-025 SHALL keep timer_int_o a level that clears only by raising mtimecmp or lowering mtime; it is independent of EN.
REQ-026 SHALL drive soft_int_o = MSIP bit0 directly.
REQ-027 SHALL return the current (pre-write) value on a read of MTIME_LO; software handles hi/lo tearing by reading hi, lo, hi.

Reset
REQ-028 SHALL, on wb_rst_i high at a clock edge, set mtime=0, mtimecmp=0xFFFF_FFFF_FFFF_FFFF, EN=EN_RST, DIV=DIV_RST, MSIP=0, pc=0.
REQ-029 SHALL, on that reset, drive wb_ack_o=0, wb_dat_o=0, timer_int_o=0, soft_int_o=0.
REQ-030 SHALL, when reset occurs mid-transfer, abort the transfer with no ack, leaving the master to retry.
REQ-031 SHALL behave as if still in reset while wb_rst_i is held high: no counting and no bus response.

Structure
REQ-032 SHALL place the register offsets and the CTRL field positions in the shared defines header alongside the existing bus constants.
REQ-033 SHALL implement the tick generator as a sub-module mtimer_prescaler (ports: clk, rst, en, div, clr, tick); the register file and compare logic stay in wb_mtimer.

Verification
REQ-034 SHALL cover counting: after reset with DIV=0, EN=1, run 10 cycles, then read MTIME_LO -> value 10 +/- bus latency (exact cycle checked against a model).
REQ-035 SHALL cover the prescaler: write CTRL=0x0003_0001, idle 40 cycles -> mtime advances by exactly 10.
REQ-036 SHALL cover the compare: write MTIMECMP_HI=0 then MTIMECMP_LO=0x20 with DIV=0 -> timer_int_o rises the cycle after mtime reaches 0x20; writing MTIMECMP_LO=0xFFFF_FFFF drops it one cycle later.
REQ-037 SHALL cover carry and wrap: write MTIME_HI=0xFFFF_FFFF and MTIME_LO=0xFFFF_FFFE -> mtime reaches 0 after 2 ticks with HI=0; a write colliding with a tick takes the written value.
REQ-038 SHALL cover byte lanes: write MTIMECMP_LO=0xAABBCCDD with sel=4'b0101 after reset -> reads back 0xFFBBFFDD; MSIP write 1 -> soft_int_o=1 on the next cycle.
REQ-039 SHALL cover reset mid-access: assert wb_rst_i in the cycle stb rises -> no ack, all outputs 0, mtimecmp reads back all ones afterwards.

Source files
------------

// File: rtl/wb_mtimer_pkg.sv
// Shared bus constants, register offsets and CTRL field positions for the machine timer.
// Also holds the byte-lane merge helper used by every writable register.
package wb_mtimer_pkg;

  // Bus geometry
  localparam int unsigned WbAdrW = 5;
  localparam int unsigned WbDatW = 32;
  localparam int unsigned WbSelW = WbDatW / 8;

  // Register byte offsets
  localparam logic [WbAdrW-1:0] MtimeLoOff    = 5'h00;
  localparam logic [WbAdrW-1:0] MtimeHiOff    = 5'h04;
  localparam logic [WbAdrW-1:0] MtimecmpLoOff = 5'h08;
  localparam logic [WbAdrW-1:0] MtimecmpHiOff = 5'h0C;
  localparam logic [WbAdrW-1:0] CtrlOff       = 5'h10;
  localparam logic [WbAdrW-1:0] MsipOff       = 5'h14;

  // CTRL field positions
  localparam int unsigned CtrlEnBit  = 0;
  localparam int unsigned CtrlDivLsb = 16;
  localparam int unsigned DivW       = 16;

  // Replace only the bytes whose lane enable is set.
  function automatic logic [WbDatW-1:0] merge_bytes(input logic [WbDatW-1:0] old_val,
                                                    input logic [WbDatW-1:0] new_val,
                                                    input logic [WbSelW-1:0] sel);
    logic [WbDatW-1:0] res;
    res = old_val;
    for (int b = 0; b < int'(WbSelW); b++) begin
      if (sel[b]) begin
        res[8*b +: 8] = new_val[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mtimer_prescaler.sv
// Tick generator: counts 0..div and pulses tick on the wrap cycle while enabled.
// A disabled prescaler holds its count at zero so a re-enable starts a full period.
module mtimer_prescaler
  import wb_mtimer_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic [DivW-1:0] div_i,
  input  logic            clr_i,
  output logic            tick_o
);

  logic [DivW-1:0] pc_q;
  logic [DivW-1:0] pc_d;

  always_comb begin
    tick_o = en_i && (pc_q == div_i);
    pc_d   = pc_q + {{(DivW-1){1'b0}}, 1'b1};
    if (clr_i || !en_i || tick_o) begin
      pc_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/wb_mtimer.sv
// Wishbone machine timer: 64-bit mtime/mtimecmp, prescaled counting, timer and software
// interrupts. Single-cycle registered ack, no wait states.
module wb_mtimer
  import wb_mtimer_pkg::*;
#(
  parameter logic [15:0] DIV_RST = 16'd0,
  parameter logic        EN_RST  = 1'b1
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [WbAdrW-1:0] wb_adr_i,
  input  logic [WbDatW-1:0] wb_dat_i,
  output logic [WbDatW-1:0] wb_dat_o,
  input  logic [WbSelW-1:0] wb_sel_i,
  input  logic              wb_we_i,
  input  logic              wb_stb_i,
  input  logic              wb_cyc_i,
  output logic              wb_ack_o,
  output logic              timer_int_o,
  output logic              soft_int_o
);

  logic [63:0]       mtime_q, mtime_d;
  logic [63:0]       mtimecmp_q, mtimecmp_d;
  logic              en_q, en_d;
  logic [DivW-1:0]   div_q, div_d;
  logic              msip_q, msip_d;
  logic              ack_q, ack_d;
  logic [WbDatW-1:0] dat_q, dat_d;
  logic              timer_q, timer_d;

  logic              req;
  logic              wr;
  logic              tick;
  logic              pc_clr;
  logic [WbAdrW-1:0] reg_off;
  logic [WbDatW-1:0] ctrl_val;
  logic [WbDatW-1:0] rdata;
  logic              unused_adr;

  // Byte offset within a word is irrelevant; only whole registers are decoded.
  assign unused_adr = ^wb_adr_i[1:0];
  assign reg_off    = {wb_adr_i[4:2], 2'b00};

  // A request is taken only while no ack is outstanding, giving ack on alternate cycles.
  assign req = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wr  = req & wb_we_i;

  always_comb begin
    ctrl_val                        = '0;
    ctrl_val[CtrlEnBit]             = en_q;
    ctrl_val[CtrlDivLsb +: DivW]    = div_q;
  end

  always_comb begin
    rdata = '0;
    case (reg_off)
      MtimeLoOff:    rdata = mtime_q[31:0];
      MtimeHiOff:    rdata = mtime_q[63:32];
      MtimecmpLoOff: rdata = mtimecmp_q[31:0];
      MtimecmpHiOff: rdata = mtimecmp_q[63:32];
      CtrlOff:       rdata = ctrl_val;
      MsipOff:       rdata = {{(WbDatW-1){1'b0}}, msip_q};
      default:       rdata = '0;
    endcase
  end

  always_comb begin
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    en_d       = en_q;
    div_d      = div_q;
    msip_d     = msip_q;

    if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end

    // A bus write to either mtime half overrides the increment for the whole counter.
    if (wr) begin
      case (reg_off)
        MtimeLoOff: begin
          mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], wb_dat_i, wb_sel_i)};
        end
        MtimeHiOff: begin
          mtime_d = {merge_bytes(mtime_q[63:32], wb_dat_i, wb_sel_i), mtime_q[31:0]};
        end
        MtimecmpLoOff: begin
          mtimecmp_d[31:0] = merge_bytes(mtimecmp_q[31:0], wb_dat_i, wb_sel_i);
        end
        MtimecmpHiOff: begin
          mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], wb_dat_i, wb_sel_i);
        end
        CtrlOff: begin
          if (wb_sel_i[CtrlEnBit / 8]) begin
            en_d = wb_dat_i[CtrlEnBit];
          end
          if (wb_sel_i[CtrlDivLsb / 8]) begin
            div_d[7:0] = wb_dat_i[CtrlDivLsb +: 8];
          end
          if (wb_sel_i[CtrlDivLsb / 8 + 1]) begin
            div_d[15:8] = wb_dat_i[CtrlDivLsb + 8 +: 8];
          end
        end
        MsipOff: begin
          if (wb_sel_i[0]) begin
            msip_d = wb_dat_i[0];
          end
        end
        default: ;
      endcase
    end

    pc_clr  = (div_d != div_q);
    ack_d   = req;
    dat_d   = (req && !wb_we_i) ? rdata : '0;
    timer_d = (mtime_d >= mtimecmp_d);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      en_q       <= EN_RST;
      div_q      <= DIV_RST;
      msip_q     <= 1'b0;
      ack_q      <= 1'b0;
      dat_q      <= '0;
      timer_q    <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      en_q       <= en_d;
      div_q      <= div_d;
      msip_q     <= msip_d;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      timer_q    <= timer_d;
    end
  end

  mtimer_prescaler u_prescaler (
    .clk_i  (wb_clk_i),
    .rst_i  (wb_rst_i),
    .en_i   (en_q),
    .div_i  (div_q),
    .clr_i  (pc_clr),
    .tick_o (tick)
  );

  assign wb_ack_o    = ack_q;
  assign wb_dat_o    = dat_q;
  assign timer_int_o = timer_q;
  assign soft_int_o  = msip_q;

endmodule
